// File: rtl/addr_gap_sched_pkg.sv
// Shared types and constants for the addr_gap lookup scheduler.
// State encoding, result widths and the default WAIT timeout.
package addr_gap_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_FIRE  = 3'd2,
        S_WAIT  = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    localparam int DEF_TIMEOUT_CYC = 15;
    localparam int GAP_W           = 12;
    localparam int OFS_W           = 8;

endpackage

// File: rtl/addr_gap_sched_rr_arbiter.sv
// Combinational round-robin next-winner search starting after i_ptr.
// Emits one-hot grant, binary index and an any-grant flag.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [ID_W-1:0]    o_idx,
    output logic               o_any
);

    // Upper half (above ptr) first, then wrap to the lower half.
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!o_any && i > int'(i_ptr) && i_req[i]) begin
                o_any    = 1'b1;
                o_gnt[i] = 1'b1;
                o_idx    = ID_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!o_any && i <= int'(i_ptr) && i_req[i]) begin
                o_any    = 1'b1;
                o_gnt[i] = 1'b1;
                o_idx    = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/addr_gap_sched.sv
// Round-robin scheduler sharing one addr_gap_gen among NUM_REQ requesters.
// Optional WAIT timeout with error response: define GAP_TIMEOUT_EN.
module addr_gap_sched
    import addr_gap_sched_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ID_W        = 2,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*32-1:0]   req_angle,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    rsp_valid,
    output logic [ID_W-1:0]         rsp_id,
    output logic [GAP_W-1:0]        rsp_addr_gap,
    output logic [OFS_W-1:0]        rsp_offset,
    output logic                    rsp_sign,
    output logic                    rsp_err,
    output logic                    busy,
    output logic [31:0]             gap_angle,
    output logic                    gap_enable,
    input  logic [GAP_W-1:0]        gap_addr_gap,
    input  logic [OFS_W-1:0]        gap_offset,
    input  logic                    gap_sign,
    input  logic                    gap_done
);

    if (TIMEOUT_CYC < 2 || (1 << ID_W) < NUM_REQ) begin : g_param_err
        $error("addr_gap_sched: bad parameters");
    end

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ID_W-1:0]    r_ptr;
    logic [ID_W-1:0]    r_id;
    logic [31:0]        r_angle;
    logic [GAP_W-1:0]   r_addr;
    logic [OFS_W-1:0]   r_ofs;
    logic               r_sign;
    logic [NUM_REQ-1:0] w_gnt;
    logic [ID_W-1:0]    w_idx;
    logic               w_any;
    logic [31:0]        w_win_angle;
    logic               w_cap;
    logic               w_limit;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .i_req (req_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    always_comb begin
        w_win_angle = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_win_angle = req_angle[32*i +: 32];
            end
        end
    end

    assign w_cap = (r_state == S_WAIT) && gap_done;

`ifdef GAP_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 4) ?
                           $clog2(TIMEOUT_CYC + 1) : 4;

    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    // Counter holds k-1 in the k-th WAIT cycle; limit hits on cycle TIMEOUT_CYC.
    assign w_limit = (r_state == S_WAIT) &&
                     ((r_cnt + CNT_W'(1)) == CNT_W'(TIMEOUT_CYC));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == S_FIRE) begin
            r_cnt <= '0;
        end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign rsp_err = r_err;
`else
    assign w_limit = 1'b0;
    assign rsp_err = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        gap_enable  = 1'b0;
        rsp_valid   = 1'b0;
        busy        = 1'b1;
        unique case (r_state)
            S_IDLE: begin
                busy      = 1'b0;
                req_ready = w_gnt;
                if (w_any) begin
                    w_state_nxt = S_SETUP;
                end
            end
            S_SETUP: w_state_nxt = S_FIRE;
            S_FIRE: begin
                gap_enable  = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (gap_done || w_limit) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid   = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ptr   <= ID_W'(NUM_REQ - 1);
            r_id    <= '0;
            r_angle <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && w_any) begin
                r_ptr   <= w_idx;
                r_id    <= w_idx;
                r_angle <= w_win_angle;
            end
        end
    end

    // gap_done wins over a timeout landing in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr <= '0;
            r_ofs  <= '0;
            r_sign <= 1'b0;
`ifdef GAP_TIMEOUT_EN
            r_err  <= 1'b0;
`endif
        end else if (w_cap) begin
            r_addr <= gap_addr_gap;
            r_ofs  <= gap_offset;
            r_sign <= gap_sign;
`ifdef GAP_TIMEOUT_EN
            r_err  <= 1'b0;
        end else if (w_limit) begin
            r_addr <= '0;
            r_ofs  <= '0;
            r_sign <= 1'b0;
            r_err  <= 1'b1;
`endif
        end
    end

    assign gap_angle    = r_angle;
    assign rsp_id       = r_id;
    assign rsp_addr_gap = r_addr;
    assign rsp_offset   = r_ofs;
    assign rsp_sign     = r_sign;

endmodule
